adc_ctrl: RTL
=============

ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 Parameter DATA_W, default 256, width of the ADC sample beat and the capture-fifo word.
REQ-002 Parameter CFG_W, default rfsoc_config::config_reg_width, width of the count and delay registers.
REQ-003 clk  input  1  250MHz clock from the RFSoC IP.
REQ-004 rst  input  1  reset: asynchronous, active-low.
REQ-005 s_axis_tdata  input  DATA_W  ADC samples from the RFSoC IP.
REQ-006 s_axis_tvalid  input  1  ADC beat valid.
REQ-007 s_axis_tready  output  1  constant 1; the ADC path is never back-pressured.
REQ-008 m_axis_tdata  output  DATA_W  captured word to the capture fifo.
REQ-009 m_axis_tvalid  output  1  captured word valid.
REQ-010 m_axis_tready  input  1  capture fifo can accept.
REQ-011 gpio_ctrl  input  16  PS configuration bus; sdata plus per-register shift strobes.
REQ-012 trigger_in  input  1  synchronization trigger that starts a capture.
REQ-013 select_in  input  1  1 = PS is configuring this channel.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 capture_done  output  1  one-cycle pulse at the end of a capture.
REQ-016 overflow  output  1  sticky flag: at least one beat was dropped in the current or last capture.

Function
REQ-017 Three CFG_W configuration registers shall load serially from gpio_ctrl[sdata], gated by select_in:
- pre_delay_cycles
- capture_count (beats to capture)
- decim (keep 1 of every decim beats)
REQ-018 The states shall be IDLE, PRE_DELAY, CAPTURE and DONE.
REQ-019 IDLE: trigger_in=1 latches all three configuration registers into working copies. The next state is PRE_DELAY, or CAPTURE if pre_delay_cycles=0. overflow clears in the same cycle.
REQ-020 trigger_in outside IDLE shall be ignored. Configuration changes after the trigger shall not affect the running capture.
REQ-021 PRE_DELAY: the block stays in PRE_DELAY for exactly pre_delay_cycles clocks, counting down, then enters CAPTURE.
REQ-022 CAPTURE with capture_count=0 goes to DONE on the next cycle and writes nothing.
REQ-023 CAPTURE, beat qualification:
- A beat is eligible when s_axis_tvalid=1 and the decimation phase is 0.
- The phase counts 0..decim-1 on every valid beat and wraps to 0.
- decim=0 or decim=1 means every valid beat is eligible.
- The first valid beat in CAPTURE is always eligible.
REQ-024 Each eligible beat shall be registered to m_axis_tdata with m_axis_tvalid=1 on the following cycle (latency 1), and shall decrement the remaining count.
REQ-025 When m_axis_tvalid=1 and m_axis_tready=0 on a cycle a new eligible beat arrives:
- the new beat is dropped and still counted;
- overflow sets;
- the held word stays stable until accepted.
REQ-026 A word is transferred when m_axis_tvalid and m_axis_tready are both 1. m_axis_tvalid then deasserts unless a new eligible beat is loaded in the same cycle.
REQ-027 When the remaining count reaches 0 the state goes to DONE. No further words are generated, and a pending output word is still held until accepted.
REQ-028 DONE: the block waits until m_axis_tvalid=0, then pulses capture_done for one cycle and returns to IDLE.
REQ-029 Counters shall be CFG_W+1 bits wide so that a value of 2^CFG_W-1 does not wrap. Count arithmetic is unsigned.

Reset
REQ-030 rst=0 shall asynchronously force:
- state IDLE;
- m_axis_tdata=0, m_axis_tvalid=0;
- busy=0, capture_done=0, overflow=0;
- all counters and the decimation phase to 0.
REQ-031 Configuration shift registers shall reset to 0.
REQ-032 Reset mid-capture abandons the capture: no capture_done is produced and a held word is discarded.

Structure
REQ-033 The following belong in rfsoc_config: the gpio_ctrl bit indices adc_pre_delay_clk, adc_capture_count_clk and adc_decim_clk, alongside the existing sdata and config_reg_width.
REQ-034 The state enumeration shall be local to adc_ctrl.
REQ-035 The configuration registers shall reuse the shared shift_register sub-module; no other sub-module.

Verification
REQ-036 Bench cases, stimulus -> required response:
- pre_delay=0, count=4, decim=1, tready=1, ADC beats 0,1,2,…, trigger → words 0..3 on consecutive cycles, the first one cycle after CAPTURE entry; capture_done one cycle after the last word; overflow=0.
- pre_delay=3 → the first captured beat is the one sampled 4 cycles after the trigger cycle; busy high from the cycle after the trigger.
- count=6, decim=3 → words = beats 0,3,6,9,12,15.
- count=4, tready held 0 → word 0 held stable, beats 1–3 dropped, overflow=1; capture_done only after tready=1 accepts word 0.
- count=0 → no words; capture_done 2 cycles after the trigger; a second trigger during busy is ignored.
- rst low mid-capture → all outputs 0 immediately; a new trigger after release runs a clean capture with overflow=0.

Source files
------------

// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration constants: config register width and the
// gpio_ctrl bit map used by the PS serial configuration interface.
package rfsoc_config;

  localparam int config_reg_width = 32;

  localparam int sdata                 = 0;
  localparam int adc_pre_delay_clk     = 1;
  localparam int adc_capture_count_clk = 2;
  localparam int adc_decim_clk         = 3;

endpackage

// File: rtl/shift_register.sv
// Serial configuration register: shifts sdata in MSB-first on each rising
// edge of its strobe while the channel is selected.
module shift_register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sclk,
  input  logic         sdata,
  output logic [W-1:0] q
);

  logic sclk_reg;

  // The strobe comes from slow PS GPIO, so only its rising edge shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_reg <= 1'b0;
      q        <= '0;
    end else begin
      sclk_reg <= sclk;
      if (en && sclk && !sclk_reg)
        q <= {q[W-2:0], sdata};
    end
  end

endmodule

// File: rtl/adc_ctrl.sv
// ADC capture controller: after a trigger, waits a programmable delay, then
// forwards a decimated, counted burst of ADC beats to the capture fifo.
module adc_ctrl
  import rfsoc_config::*;
#(
  parameter int DATA_W = 256,
  parameter int CFG_W  = config_reg_width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [15:0]       gpio_ctrl,
  input  logic              trigger_in,
  input  logic              select_in,
  output logic              busy,
  output logic              capture_done,
  output logic              overflow
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRE_DELAY = 2'd1;
  localparam logic [1:0] CAPTURE   = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  // cfg[0] = pre-delay cycles, cfg[1] = capture count, cfg[2] = decimation
  logic [2:0]       strobe;
  logic [CFG_W-1:0] cfg [3];

  assign strobe = {gpio_ctrl[adc_decim_clk], gpio_ctrl[adc_capture_count_clk],
                   gpio_ctrl[adc_pre_delay_clk]};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      shift_register #(.W(CFG_W)) u_cfg (
        .clk   (clk),
        .rst   (rst),
        .en    (select_in),
        .sclk  (strobe[gi]),
        .sdata (gpio_ctrl[sdata]),
        .q     (cfg[gi])
      );
    end
  endgenerate

  logic [1:0]        state_reg;
  logic [CFG_W:0]    delay_cnt_reg;
  logic [CFG_W:0]    remain_cnt_reg;
  logic [CFG_W-1:0]  decim_reg;
  logic [CFG_W:0]    phase_reg;
  logic [CFG_W:0]    phase_inc;
  logic [CFG_W:0]    phase_next;
  logic [DATA_W-1:0] tdata_reg;
  logic              tvalid_reg;
  logic              overflow_reg;
  logic              capturing;
  logic              eligible;
  logic              accept;
  logic              load;
  logic              drop;

  assign capturing  = (state_reg == CAPTURE) && (remain_cnt_reg != '0);
  assign eligible   = capturing && s_axis_tvalid && (phase_reg == '0);
  assign accept     = tvalid_reg && m_axis_tready;
  // A held word that is being accepted this cycle frees the slot for a new one.
  assign load       = eligible && (!tvalid_reg || m_axis_tready);
  assign drop       = eligible && tvalid_reg && !m_axis_tready;
  assign phase_inc  = phase_reg + 1'b1;
  assign phase_next = (phase_inc >= {1'b0, decim_reg}) ? '0 : phase_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      delay_cnt_reg  <= '0;
      remain_cnt_reg <= '0;
      decim_reg      <= '0;
      phase_reg      <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (load) begin
        tdata_reg  <= s_axis_tdata;
        tvalid_reg <= 1'b1;
      end else if (accept) begin
        tvalid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (trigger_in) begin
            delay_cnt_reg  <= {1'b0, cfg[0]};
            remain_cnt_reg <= {1'b0, cfg[1]};
            decim_reg      <= cfg[2];
            phase_reg      <= '0;
            overflow_reg   <= 1'b0;
            state_reg      <= (cfg[0] == '0) ? CAPTURE : PRE_DELAY;
          end
        end
        PRE_DELAY: begin
          delay_cnt_reg <= delay_cnt_reg - 1'b1;
          if (delay_cnt_reg <= 1)
            state_reg <= CAPTURE;
        end
        CAPTURE: begin
          if (capturing && s_axis_tvalid)
            phase_reg <= phase_next;
          if (eligible)
            remain_cnt_reg <= remain_cnt_reg - 1'b1;
          if (drop)
            overflow_reg <= 1'b1;
          if ((remain_cnt_reg == '0) || (eligible && remain_cnt_reg == 1))
            state_reg <= DONE;
        end
        default: begin
          if (!tvalid_reg)
            state_reg <= IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign busy          = (state_reg != IDLE);
  assign capture_done  = (state_reg == DONE) && !tvalid_reg;
  assign overflow      = overflow_reg;

endmodule
